spi_flash_rd_seq: RTL and testbench

Hardware read sequencer for the iCE40 `SB_SPI` hard IP, used in master mode towards the configuration flash on CS0. It owns the 8-bit system bus of the SPI core (`sb_*`), programs the core once after reset, and then serves stream-style read requests. Each request issues a standard flash READ command, a 24-bit address, and N data bytes; the data bytes are delivered on a valid/ready byte stream. It sits between the SoC (or a DMA-like consumer) and `SB_SPI`, in place of firmware bit-banging the SPI registers.

---
 rtl/spi_flash_rd_seq.sv | 253 +++++++++++++++++++++++++
 tb/tb_spi_flash_rd_seq.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_rd_seq.sv
// spi_flash_rd_seq: hardware read sequencer for the iCE40 SB_SPI hard IP.
// Programs the SPI core once after reset, then serves flash READ requests
// (opcode, 24-bit address, N data bytes) and streams the data bytes out on
// a valid/ready interface. All SB accesses use a strobe/ack handshake with
// at least one idle cycle between consecutive strobes.
module spi_flash_rd_seq #(
  parameter logic [5:0]  CLK_DIV = 6'd0,
  parameter int unsigned LEN_W   = 16,
  parameter logic [7:0]  CMD     = 8'h03
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done,
  output logic             busy,
  output logic [7:0]       sb_addr,
  output logic [7:0]       sb_di,
  input  logic [7:0]       sb_do,
  output logic             sb_rw,
  output logic             sb_stb,
  input  logic             sb_ack
);

  localparam logic [7:0] SPICR1  = 8'h09;
  localparam logic [7:0] SPICR2  = 8'h0A;
  localparam logic [7:0] SPIBR   = 8'h0B;
  localparam logic [7:0] SPISR   = 8'h0C;
  localparam logic [7:0] SPITXDR = 8'h0D;
  localparam logic [7:0] SPIRXDR = 8'h0E;
  localparam logic [7:0] SPICSR  = 8'h0F;

  localparam int unsigned SR_TRDY = 4;
  localparam int unsigned SR_RRDY = 3;

  // XFER is split into its four SB steps; CS_OFF into poll + write.
  typedef enum logic [3:0] {
    S_INIT,
    S_IDLE,
    S_CS_ON,
    S_TX_POLL,
    S_TX_WR,
    S_RX_POLL,
    S_RX_RD,
    S_OUT,
    S_OFF_POLL,
    S_OFF_WR,
    S_DONE
  } state_t;

  state_t           state;
  logic [1:0]       init_step;
  logic [2:0]       byte_idx;
  logic [23:0]      addr_q;
  logic [LEN_W-1:0] remain;

  logic             acc_req;
  logic             acc_rw;
  logic [7:0]       acc_addr;
  logic [7:0]       acc_di;
  logic [7:0]       tx_byte;
  logic             sb_xfer;

  // An access completes in the cycle the core acknowledges the strobe.
  assign sb_xfer = sb_stb & sb_ack;
  assign busy    = (state != S_IDLE);

  // Decode which SB access the current state needs (if any).
  always_comb begin
    tx_byte = 8'h00;
    case (byte_idx)
      3'd0:    tx_byte = CMD;
      3'd1:    tx_byte = addr_q[23:16];
      3'd2:    tx_byte = addr_q[15:8];
      3'd3:    tx_byte = addr_q[7:0];
      default: tx_byte = 8'h00;
    endcase

    acc_req  = 1'b1;
    acc_rw   = 1'b0;
    acc_addr = SPISR;
    acc_di   = '0;
    case (state)
      S_INIT: begin
        acc_rw = 1'b1;
        case (init_step)
          2'd0: begin
            acc_addr = SPICR1;
            acc_di   = 8'h80;
          end
          2'd1: begin
            acc_addr = SPICR2;
            acc_di   = 8'hC0;
          end
          default: begin
            acc_addr = SPIBR;
            acc_di   = {2'b00, CLK_DIV};
          end
        endcase
      end
      S_CS_ON: begin
        acc_rw   = 1'b1;
        acc_addr = SPICSR;
        acc_di   = 8'hFE;
      end
      S_TX_POLL, S_RX_POLL, S_OFF_POLL: begin
        acc_rw   = 1'b0;
        acc_addr = SPISR;
      end
      S_TX_WR: begin
        acc_rw   = 1'b1;
        acc_addr = SPITXDR;
        acc_di   = tx_byte;
      end
      S_RX_RD: begin
        acc_rw   = 1'b0;
        acc_addr = SPIRXDR;
      end
      S_OFF_WR: begin
        acc_rw   = 1'b1;
        acc_addr = SPICSR;
        acc_di   = 8'hFF;
      end
      default: acc_req = 1'b0;
    endcase
  end

  // Sequencer FSM with registered SB and stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      init_step <= '0;
      byte_idx  <= '0;
      addr_q    <= '0;
      remain    <= '0;
      sb_stb    <= 1'b0;
      sb_rw     <= 1'b0;
      sb_addr   <= '0;
      sb_di     <= '0;
      req_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      // A new strobe is only launched from an idle bus, and the strobe drops
      // in the ack cycle, so consecutive accesses are always separated by a
      // low cycle and the address/data/rw only move while the bus is idle.
      if (acc_req && !sb_stb) begin
        sb_stb  <= 1'b1;
        sb_rw   <= acc_rw;
        sb_addr <= acc_addr;
        sb_di   <= acc_di;
      end else if (sb_xfer) begin
        sb_stb <= 1'b0;
      end

      case (state)
        S_INIT: begin
          if (sb_xfer) begin
            if (init_step == 2'd2) begin
              state     <= S_IDLE;
              req_ready <= 1'b1;
            end else begin
              init_step <= init_step + 2'd1;
            end
          end
        end

        S_IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            remain    <= req_len;
            byte_idx  <= '0;
            req_ready <= 1'b0;
            if (req_len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_CS_ON;
            end
          end
        end

        S_CS_ON: begin
          if (sb_xfer) begin
            byte_idx <= '0;
            state    <= S_TX_POLL;
          end
        end

        S_TX_POLL: begin
          if (sb_xfer && sb_do[SR_TRDY]) state <= S_TX_WR;
        end

        S_TX_WR: begin
          if (sb_xfer) state <= S_RX_POLL;
        end

        S_RX_POLL: begin
          if (sb_xfer && sb_do[SR_RRDY]) state <= S_RX_RD;
        end

        S_RX_RD: begin
          if (sb_xfer) begin
            if (byte_idx < 3'd4) begin
              byte_idx <= byte_idx + 3'd1;
              state    <= S_TX_POLL;
            end else begin
              out_data  <= sb_do;
              out_valid <= 1'b1;
              state     <= S_OUT;
            end
          end
        end

        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            remain    <= remain - 1'b1;
            if (remain == LEN_W'(1)) state <= S_OFF_POLL;
            else                     state <= S_TX_POLL;
          end
        end

        S_OFF_POLL: begin
          if (sb_xfer && sb_do[SR_TRDY]) state <= S_OFF_WR;
        end

        S_OFF_WR: begin
          if (sb_xfer) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end

        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// Testbench for spi_flash_rd_seq: an SB_SPI core + SPI flash model answers the
// bus, a scoreboard holds the expected SB writes, status-poll counts, data
// bytes and done pulses, and a monitor checks them as the DUT produces them.
module tb_spi_flash_rd_seq;

  localparam logic [5:0]  CLK_DIV_V = 6'd5;
  localparam int unsigned LEN_W_V   = 16;
  localparam logic [7:0]  CMD_V     = 8'h03;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req_valid;
  logic               req_ready;
  logic [23:0]        req_addr;
  logic [LEN_W_V-1:0] req_len;
  logic [7:0]         out_data;
  logic               out_valid;
  logic               out_ready;
  logic               done;
  logic               busy;
  logic [7:0]         sb_addr;
  logic [7:0]         sb_di;
  logic [7:0]         sb_do;
  logic               sb_rw;
  logic               sb_stb;
  logic               sb_ack;

  spi_flash_rd_seq #(
    .CLK_DIV (CLK_DIV_V),
    .LEN_W   (LEN_W_V),
    .CMD     (CMD_V)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (done),
    .busy      (busy),
    .sb_addr   (sb_addr),
    .sb_di     (sb_di),
    .sb_do     (sb_do),
    .sb_rw     (sb_rw),
    .sb_stb    (sb_stb),
    .sb_ack    (sb_ack)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Scoreboard
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_out[$];
  int          exp_poll[$];
  int          tst_q[$];
  int          rst_q[$];
  int          exp_done = 0;
  int          done_cnt = 0;
  int          stb_rises = 0;
  int          out_seen = 0;
  int          bp_hold = 0;
  bit          bp_arm = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Flash contents as a pure function of the byte address.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ (a[23:16] + 8'h3C);
  endfunction

  // SB_SPI core + flash model: single-byte TX/RX buffer, per-transfer status stalls.
  bit          m_cs;
  bit          m_rxp;
  int          m_bcnt;
  int          m_tst;
  int          m_rst;
  logic [23:0] m_addr;
  logic [7:0]  m_rxd;

  initial begin
    sb_ack = 1'b0;
    sb_do  = 8'h00;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        sb_ack <= 1'b0;
        sb_do  <= 8'h00;
        m_cs = 0; m_rxp = 0; m_bcnt = 0; m_tst = 0; m_rst = 0;
        m_addr = '0; m_rxd = '0;
      end else if (sb_ack) begin
        sb_ack <= 1'b0;
      end else if (sb_stb && $urandom_range(0, 2) != 0) begin
        sb_ack <= 1'b1;
        if (sb_rw) begin
          if (sb_addr == 8'h0F) begin
            if (sb_di == 8'hFE) begin
              m_cs = 1; m_bcnt = 0;
              m_tst = (tst_q.size() > 0) ? tst_q.pop_front() : 0;
            end else begin
              m_cs = 0;
            end
          end else if (sb_addr == 8'h0D) begin
            if (!m_cs) m_rxd = 8'h00;
            else if (m_bcnt < 4) begin
              m_rxd = 8'hFF;
              if (m_bcnt > 0) m_addr = {m_addr[15:0], sb_di};
            end else begin
              m_rxd = flash_byte(m_addr + 24'(m_bcnt - 4));
            end
            m_bcnt++;
            m_rxp = 1;
            m_rst = (rst_q.size() > 0) ? rst_q.pop_front() : 0;
          end
        end else begin
          if (sb_addr == 8'h0C) begin
            if (m_rxp) begin
              if (m_rst > 0) begin sb_do <= 8'h00; m_rst--; end
              else sb_do <= 8'h08;
            end else begin
              if (m_tst > 0) begin sb_do <= 8'h00; m_tst--; end
              else sb_do <= 8'h10;
            end
          end else if (sb_addr == 8'h0E) begin
            sb_do <= m_rxd;
            m_rxp = 0;
            m_tst = (tst_q.size() > 0) ? tst_q.pop_front() : 0;
          end else begin
            sb_do <= 8'h00;
          end
        end
      end
    end
  end

  // Consumer: random out_ready, optionally a 20-cycle stall on the second byte.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bp_arm && out_valid && out_seen == 1) begin
        bp_hold = 20;
        bp_arm  = 1'b0;
      end
      if (bp_hold > 0) begin
        out_ready = 1'b0;
        bp_hold--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor
  logic        p_stb, p_ack, p_rw, p_valid, p_ready, p_done;
  logic [7:0]  p_addr, p_di, p_data;
  logic [15:0] w;
  int          poll = 0;

  task automatic check_poll(input string name);
    int e;
    e = (exp_poll.size() > 0) ? exp_poll.pop_front() : -1;
    chk(name, 64'(poll), 64'(e));
  endtask

  initial begin
    p_stb = 0; p_ack = 0; p_rw = 0; p_valid = 0; p_ready = 0; p_done = 0;
    p_addr = 0; p_di = 0; p_data = 0; w = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_stb = 0; p_ack = 0; p_valid = 0; p_ready = 0; p_done = 0;
        poll = 0;
      end else begin
        if (p_stb && !p_ack)
          chk("sb_hold", 64'({sb_stb, sb_rw, sb_addr, sb_di}), 64'({1'b1, p_rw, p_addr, p_di}));
        if (p_stb && p_ack)
          chk("sb_gap", 64'(sb_stb), 64'(0));
        if (sb_stb && !p_stb) stb_rises++;

        if (sb_stb && sb_ack) begin
          if (sb_rw) begin
            chk("sb_write_expected", 64'(exp_wr.size() != 0), 64'(1));
            if (exp_wr.size() != 0) begin
              w = exp_wr.pop_front();
              chk("sb_write", 64'({sb_addr, sb_di}), 64'(w));
            end
            if (sb_addr == 8'h0D || (sb_addr == 8'h0F && sb_di == 8'hFF))
              check_poll("polls_before_write");
            poll = 0;
          end else if (sb_addr == 8'h0C) begin
            poll++;
          end else begin
            chk("sb_read_addr", 64'(sb_addr), 64'(8'h0E));
            check_poll("polls_before_rxdr");
            poll = 0;
          end
        end

        if (p_valid && !p_ready)
          chk("out_hold", 64'({out_valid, out_data}), 64'({1'b1, p_data}));
        if (out_valid)
          chk("no_sb_while_out", 64'(sb_stb), 64'(0));
        if (out_valid && out_ready) begin
          chk("out_expected", 64'(exp_out.size() != 0), 64'(1));
          if (exp_out.size() != 0) chk("out_data", 64'(out_data), 64'(exp_out.pop_front()));
          out_seen++;
        end

        if (done) begin
          chk("done_width", 64'(p_done), 64'(0));
          chk("done_expected", 64'(exp_done > 0), 64'(1));
          if (exp_done > 0) exp_done--;
          chk("done_drained", 64'(exp_wr.size() + exp_out.size() + exp_poll.size()), 64'(0));
          done_cnt++;
        end

        chk("ready_vs_busy", 64'(req_ready), 64'(!busy));

        p_stb = sb_stb; p_ack = sb_ack; p_rw = sb_rw; p_addr = sb_addr; p_di = sb_di;
        p_valid = out_valid; p_ready = out_ready; p_data = out_data; p_done = done;
      end
    end
  end

  // Stimulus helpers
  task automatic reset_seq();
    exp_wr.delete(); exp_out.delete(); exp_poll.delete();
    tst_q.delete(); rst_q.delete();
    exp_done = 0;
    bp_arm   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_values",
        64'({sb_stb, sb_rw, sb_addr, sb_di, req_ready, out_valid, out_data, done, busy}),
        64'({1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1}));
    exp_wr.push_back({8'h09, 8'h80});
    exp_wr.push_back({8'h0A, 8'hC0});
    exp_wr.push_back({8'h0B, {2'b00, CLK_DIV_V}});
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("first_strobe", 64'(sb_stb), 64'(1));
  endtask

  task automatic issue(input logic [23:0] a, input int unsigned len,
                       input int tfix, input int rfix, input bit bp);
    int          t;
    int          r;
    logic [7:0]  txb;
    bit          acc;
    if (len != 0) begin
      exp_wr.push_back({8'h0F, 8'hFE});
      for (int unsigned i = 0; i < len + 4; i++) begin
        t = (tfix < 0) ? int'($urandom_range(0, 3)) : tfix;
        r = (rfix < 0) ? int'($urandom_range(0, 3)) : rfix;
        tst_q.push_back(t);
        rst_q.push_back(r);
        exp_poll.push_back(t + 1);
        exp_poll.push_back(r + 1);
        case (i)
          0:       txb = CMD_V;
          1:       txb = a[23:16];
          2:       txb = a[15:8];
          3:       txb = a[7:0];
          default: txb = 8'h00;
        endcase
        exp_wr.push_back({8'h0D, txb});
      end
      t = (tfix < 0) ? int'($urandom_range(0, 3)) : tfix;
      tst_q.push_back(t);
      exp_poll.push_back(t + 1);
      exp_wr.push_back({8'h0F, 8'hFF});
      for (int unsigned k = 0; k < len; k++) exp_out.push_back(flash_byte(a + 24'(k)));
    end
    exp_done++;
    out_seen = 0;
    bp_arm   = bp;

    @(posedge clk); #1;
    req_addr  = a;
    req_len   = LEN_W_V'(len);
    req_valid = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 3000 && !acc; c++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk); #1;
        req_valid = 1'b0;
        acc = 1'b1;
      end
    end
    chk("req_accept", 64'(acc), 64'(1));
    req_valid = 1'b0;
    if (acc) begin
      @(negedge clk);
      chk("ready_falls", 64'(req_ready), 64'(0));
      if (len == 0) chk("zero_len_done_latency", 64'(done), 64'(1));
    end
  endtask

  task automatic run_req(input logic [23:0] a, input int unsigned len,
                         input int tfix, input int rfix, input bit bp);
    int d0;
    int s0;
    d0 = done_cnt;
    s0 = stb_rises;
    issue(a, len, tfix, rfix, bp);
    for (int c = 0; c < 4000 && done_cnt == d0; c++) @(posedge clk);
    chk("req_done", 64'(done_cnt - d0), 64'(1));
    chk("out_count", 64'(out_seen), 64'(len));
    if (len == 0) chk("zero_len_no_sb", 64'(stb_rises - s0), 64'(0));
  endtask

  initial begin
    bit seen;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    rst_n     = 1'b0;

    // Request presented during INIT is held off until req_ready.
    reset_seq();
    run_req(24'h123456, 3, 0, 0, 1'b0);
    run_req(24'h123456, 3, 0, 0, 1'b1);
    run_req(24'h00A5F0, 2, 5, 3, 1'b0);
    run_req(24'h777777, 0, 0, 0, 1'b0);
    run_req(24'hFFFFFE, 4, -1, -1, 1'b0);
    for (int i = 0; i < 10; i++)
      run_req(24'($urandom), $urandom_range(0, 6), -1, -1, 1'b0);

    // Asynchronous reset while the second data byte is in flight.
    issue(24'hABCDEF, 4, -1, -1, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(posedge clk);
      seen = (out_seen >= 1);
    end
    chk("mid_reset_first_byte", 64'(seen), 64'(1));
    repeat ($urandom_range(1, 6)) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 64'({sb_stb, out_valid, busy, req_ready}), 64'({1'b0, 1'b0, 1'b1, 1'b0}));
    reset_seq();
    run_req(24'h000010, 2, -1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
